trng_ctrl: RTL and testbench

Sequencing controller for the ring-oscillator TRNG macro. It powers the oscillator bank up and holds it through a warm-up period. It then samples the raw bit stream, applies von Neumann debiasing and a repetition-count health test, and packs accepted bits into words. Finished words go to a bus-side consumer over a valid/ready handshake. The block sits between the TRNG macro (`trng_en`/`trng_out`) and the peripheral register interface.

---
 rtl/trng_ctrl_pkg.sv | 16 +
 rtl/trng_vn_debias.sv | 34 +++
 rtl/trng_ctrl.sv | 157 +++++++++++++++
 tb/tb_trng_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/trng_ctrl_pkg.sv
// Shared state encoding and default sizing for the TRNG sequencing controller.
package trng_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WARMUP  = 3'd1,
      ST_COLLECT = 3'd2,
      ST_HOLD    = 3'd3,
      ST_FAIL    = 3'd4
   } trng_ctrl_state_e;

   localparam int DEF_WARMUP_CYCLES = 256;
   localparam int DEF_WORD_W        = 32;
   localparam int DEF_REP_LIMIT     = 32;

endpackage

// File: rtl/trng_vn_debias.sv
// Von Neumann pair debiaser: strobes the first bit of each unequal pair.
// Output is combinational on the odd-phase sample; no backpressure, caller gates i_sample.
module trng_vn_debias (
   input  logic clk,
   input  logic rst_n,
   input  logic i_sample,
   input  logic i_clear,
   input  logic i_bit,
   output logic o_acc_vld,
   output logic o_acc_bit
);

   logic r_phase;
   logic r_a;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_phase <= 1'b0;
         r_a     <= 1'b0;
      end else if (i_clear) begin
         r_phase <= 1'b0;
         r_a     <= 1'b0;
      end else if (i_sample) begin
         if (!r_phase) begin
            r_a <= i_bit;
         end
         r_phase <= ~r_phase;
      end
   end

   assign o_acc_vld = i_sample && !i_clear && r_phase && (r_a != i_bit);
   assign o_acc_bit = r_a;

endmodule

// File: rtl/trng_ctrl.sv
// TRNG sequencer: warm-up, debiased collection with repetition health test, word hand-off.
// Word ready 2*WORD_W samples after collection starts; HOLD freezes sampling until valid&&ready.
module trng_ctrl
   import trng_ctrl_pkg::*;
#(
   parameter int WARMUP_CYCLES = DEF_WARMUP_CYCLES,
   parameter int WORD_W        = DEF_WORD_W,
   parameter int REP_LIMIT     = DEF_REP_LIMIT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable_i,
   output logic              trng_en_o,
   input  logic              trng_bit_i,
   output logic [WORD_W-1:0] data_o,
   output logic              valid_o,
   input  logic              ready_i,
   output logic              error_o,
   output logic              busy_o
);

   localparam int WU_W = $clog2(WARMUP_CYCLES + 1);
   localparam int BC_W = $clog2(WORD_W + 1);
   localparam int RP_W = $clog2(REP_LIMIT + 1);

   trng_ctrl_state_e r_state, w_state_nxt;

   logic [WU_W-1:0]   r_wu_cnt;
   logic [BC_W-1:0]   r_bit_cnt;
   logic [RP_W-1:0]   r_rep_cnt;
   logic              r_last_bit;
   logic [WORD_W-1:0] r_shreg;
   logic [WORD_W-1:0] r_data;
   logic              r_valid;
   logic              r_error;
   logic              r_trng_en;
   logic              r_busy;

   logic              w_sample;
   logic              w_clear;
   logic              w_acc_vld;
   logic              w_acc_bit;
   logic              w_xfer;
   logic              w_rep_same;
   logic              w_rep_hit;
   logic [RP_W-1:0]   w_rep_nxt;
   logic              w_word_done;
   logic [WORD_W-1:0] w_shreg_nxt;

   assign w_sample    = (r_state == ST_COLLECT);
   assign w_clear     = (r_state != ST_COLLECT);
   assign w_xfer      = r_valid && ready_i;
   assign w_shreg_nxt = {r_shreg[WORD_W-2:0], w_acc_bit};
   assign w_word_done = w_acc_vld && (r_bit_cnt == BC_W'(WORD_W - 1));

   // Run length of identical raw samples; a zero count means no sample seen yet.
   assign w_rep_same = (r_rep_cnt != '0) && (trng_bit_i == r_last_bit);
   assign w_rep_nxt  = !w_rep_same                    ? RP_W'(1) :
                       (r_rep_cnt == RP_W'(REP_LIMIT)) ? r_rep_cnt :
                                                         r_rep_cnt + RP_W'(1);
   assign w_rep_hit  = w_sample && w_rep_same && (r_rep_cnt >= RP_W'(REP_LIMIT - 1));

   trng_vn_debias u_debias (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_sample  (w_sample),
      .i_clear   (w_clear),
      .i_bit     (trng_bit_i),
      .o_acc_vld (w_acc_vld),
      .o_acc_bit (w_acc_bit)
   );

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:    if (enable_i) w_state_nxt = ST_WARMUP;
         ST_WARMUP:  if (r_wu_cnt == WU_W'(1)) w_state_nxt = ST_COLLECT;
         ST_COLLECT: begin
            if (w_rep_hit)        w_state_nxt = ST_FAIL;
            else if (w_word_done) w_state_nxt = ST_HOLD;
         end
         ST_HOLD:    if (w_xfer) w_state_nxt = ST_COLLECT;
         ST_FAIL:    w_state_nxt = ST_FAIL;
         default:    w_state_nxt = ST_IDLE;
      endcase
      if (!enable_i) begin
         w_state_nxt = ST_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Outputs are flopped from the next state so nothing reaches a port combinationally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_trng_en <= 1'b0;
         r_valid   <= 1'b0;
         r_error   <= 1'b0;
         r_busy    <= 1'b0;
         r_data    <= '0;
      end else begin
         r_trng_en <= (w_state_nxt == ST_WARMUP) || (w_state_nxt == ST_COLLECT) ||
                      (w_state_nxt == ST_HOLD);
         r_valid   <= (w_state_nxt == ST_HOLD);
         r_error   <= (w_state_nxt == ST_FAIL);
         r_busy    <= (w_state_nxt != ST_IDLE);
         if (r_state == ST_COLLECT && w_state_nxt == ST_HOLD) begin
            r_data <= w_shreg_nxt;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wu_cnt   <= '0;
         r_bit_cnt  <= '0;
         r_shreg    <= '0;
         r_rep_cnt  <= '0;
         r_last_bit <= 1'b0;
      end else begin
         if (r_state == ST_IDLE) begin
            r_wu_cnt <= WU_W'(WARMUP_CYCLES);
         end else if (r_state == ST_WARMUP && r_wu_cnt != '0) begin
            r_wu_cnt <= r_wu_cnt - WU_W'(1);
         end

         if (r_state == ST_IDLE || w_xfer) begin
            r_bit_cnt <= '0;
            r_shreg   <= '0;
         end else if (w_acc_vld) begin
            r_bit_cnt <= r_bit_cnt + BC_W'(1);
            r_shreg   <= w_shreg_nxt;
         end

         if (r_state == ST_IDLE || r_state == ST_WARMUP) begin
            r_rep_cnt  <= '0;
            r_last_bit <= 1'b0;
         end else if (w_sample) begin
            r_rep_cnt  <= w_rep_nxt;
            r_last_bit <= trng_bit_i;
         end
      end
   end

   assign trng_en_o = r_trng_en;
   assign data_o    = r_data;
   assign valid_o   = r_valid;
   assign error_o   = r_error;
   assign busy_o    = r_busy;

endmodule

// File: tb/tb_trng_ctrl.sv
// Directed bench for trng_ctrl with WARMUP_CYCLES=4, WORD_W=8, REP_LIMIT=32.
module tb_trng_ctrl;

   localparam int WU  = 4;
   localparam int WW  = 8;
   localparam int REP = 32;

   logic          clk;
   logic          rst_n;
   logic          enable_i;
   logic          trng_en_o;
   logic          trng_bit_i;
   logic [WW-1:0] data_o;
   logic          valid_o;
   logic          ready_i;
   logic          error_o;
   logic          busy_o;

   int n_cmp;
   int n_mis;

   trng_ctrl #(
      .WARMUP_CYCLES (WU),
      .WORD_W        (WW),
      .REP_LIMIT     (REP)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable_i   (enable_i),
      .trng_en_o  (trng_en_o),
      .trng_bit_i (trng_bit_i),
      .data_o     (data_o),
      .valid_o    (valid_o),
      .ready_i    (ready_i),
      .error_o    (error_o),
      .busy_o     (busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // One clock: present the bit, take the edge, settle 1ns past it.
   task automatic step(input logic b);
      trng_bit_i = b;
      @(posedge clk);
      #1;
   endtask

   task automatic feed_bits(input logic [63:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         step(bits[i]);
      end
   endtask

   task automatic transfer();
      ready_i = 1'b1;
      step(1'b0);
      ready_i = 1'b0;
   endtask

   initial begin
      n_cmp      = 0;
      n_mis      = 0;
      rst_n      = 1'b0;
      enable_i   = 1'b0;
      ready_i    = 1'b0;
      trng_bit_i = 1'b0;
      #23;
      chk_eq("rst_trng_en", trng_en_o, 0);
      chk_eq("rst_valid",   valid_o,   0);
      chk_eq("rst_error",   error_o,   0);
      chk_eq("rst_busy",    busy_o,    0);
      chk_eq("rst_data",    data_o,    0);
      rst_n = 1'b1;
      step(1'b0);
      step(1'b0);

      // Warm-up then alternating 1,0 source: every pair accepted as 1.
      enable_i = 1'b1;
      step(1'b0);
      chk_eq("en_trng_en", trng_en_o, 1);
      chk_eq("en_busy",    busy_o,    1);
      feed_bits(64'h5, WU);
      chk_eq("wu_valid", valid_o, 0);
      feed_bits(64'h5555, 15);
      chk_eq("w1_early_valid", valid_o, 0);
      step(1'b0);
      chk_eq("w1_valid", valid_o, 1);
      chk_eq("w1_data",  data_o,  8'hFF);

      // Pairs 00,11,10,01 repeated: only 10 and 01 contribute.
      transfer();
      chk_eq("xfer1_valid_drop", valid_o, 0);
      feed_bits(64'h39393939 >> 1, 31);
      chk_eq("w2_early_valid", valid_o, 0);
      step(1'b1);
      chk_eq("w2_valid", valid_o, 1);
      chk_eq("w2_data",  data_o,  8'hAA);

      // Backpressure with a stuck-1 source: health test must stay frozen.
      for (int i = 0; i < 50; i++) begin
         step(1'b1);
         if (i % 10 == 9) begin
            chk_eq("bp_valid", valid_o, 1);
            chk_eq("bp_data",  data_o,  8'hAA);
         end
      end
      chk_eq("bp_error", error_o, 0);
      transfer();
      chk_eq("xfer2_valid_drop", valid_o, 0);
      feed_bits(64'h696A >> 1, 15);
      chk_eq("w3_early_valid", valid_o, 0);
      step(1'b0);
      chk_eq("w3_valid", valid_o, 1);
      chk_eq("w3_data",  data_o,  8'h67);

      // Disable after 5 accepted bits, then re-enable with full warm-up.
      transfer();
      feed_bits(64'h2AA, 10);
      enable_i = 1'b0;
      step(1'b1);
      chk_eq("dis_busy",    busy_o,    0);
      chk_eq("dis_trng_en", trng_en_o, 0);
      chk_eq("dis_valid",   valid_o,   0);
      enable_i = 1'b1;
      step(1'b0);
      chk_eq("reen_trng_en", trng_en_o, 1);
      feed_bits(64'hA, WU);
      feed_bits(64'h6666 >> 1, 15);
      chk_eq("w4_early_valid", valid_o, 0);
      step(1'b0);
      chk_eq("w4_valid", valid_o, 1);
      chk_eq("w4_data",  data_o,  8'h55);

      // Stuck-at-1 source: FAIL on the 32nd collected sample.
      transfer();
      for (int i = 0; i < REP - 1; i++) step(1'b1);
      chk_eq("hf_pre_error",   error_o,   0);
      chk_eq("hf_pre_trng_en", trng_en_o, 1);
      step(1'b1);
      chk_eq("hf_error",   error_o,   1);
      chk_eq("hf_trng_en", trng_en_o, 0);
      chk_eq("hf_valid",   valid_o,   0);
      chk_eq("hf_busy",    busy_o,    1);
      for (int i = 0; i < 5; i++) step(1'b0);
      chk_eq("hf_sticky", error_o, 1);
      enable_i = 1'b0;
      step(1'b0);
      chk_eq("hf_clr_error", error_o, 0);
      chk_eq("hf_clr_busy",  busy_o,  0);

      // Asynchronous reset while in HOLD.
      enable_i = 1'b1;
      step(1'b0);
      feed_bits(64'h0, WU);
      feed_bits(64'h5555 << 1, 16);
      chk_eq("ar_hold_valid", valid_o, 1);
      #2;
      rst_n    = 1'b0;
      enable_i = 1'b0;
      #1;
      chk_eq("ar_hold_valid0", valid_o,   0);
      chk_eq("ar_hold_data0",  data_o,    0);
      chk_eq("ar_hold_busy0",  busy_o,    0);
      chk_eq("ar_hold_en0",    trng_en_o, 0);
      rst_n = 1'b1;
      step(1'b0);

      // Asynchronous reset while in COLLECT.
      enable_i = 1'b1;
      step(1'b0);
      feed_bits(64'h0, WU);
      feed_bits(64'h5, 3);
      chk_eq("ar_col_busy", busy_o, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_eq("ar_col_busy0",  busy_o,    0);
      chk_eq("ar_col_en0",    trng_en_o, 0);
      chk_eq("ar_col_error0", error_o,   0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
